// File: rtl/mmio_store_sink_if.sv
// Bus bundle for mmio_store_sink: the CPU store/read port and the downstream stream.
// Optional STORE_SINK_TIMESTAMP_EN adds the out_ts head-stamp signal.
interface mmio_store_sink_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        overflow;
`ifdef STORE_SINK_TIMESTAMP_EN
    logic [15:0] out_ts;
`endif

    modport slave (
        input  MemWrite, DataAdr, WriteData, out_ready,
        output ReadData, Hit, out_valid, out_data, overflow
`ifdef STORE_SINK_TIMESTAMP_EN
        , output out_ts
`endif
    );

    modport master (
        output MemWrite, DataAdr, WriteData, out_ready,
        input  ReadData, Hit, out_valid, out_data, overflow
`ifdef STORE_SINK_TIMESTAMP_EN
        , input out_ts
`endif
    );
endinterface

// File: rtl/mmio_store_sink.sv
// Memory-mapped store sink: CPU stores to DATA are queued in a FIFO and drained over valid/ready.
// Define STORE_SINK_TIMESTAMP_EN to stamp each accepted word with a free-running 16-bit cycle count.
module mmio_store_sink #(
    parameter logic [31:0] BASE_ADR = 32'h0000_0100,
    parameter int          DEPTH    = 8
) (
    input  logic               clk,
    input  logic               reset,
    mmio_store_sink_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             drain_en_q, drain_en_d;

    logic sel_data, sel_status, sel_ctrl;
    logic full, empty, push_req, push_ok, pop, drop, ovf_clr;
    logic [31:0] status;

`ifdef STORE_SINK_TIMESTAMP_EN
    logic [15:0] ts_mem [DEPTH];
    logic [15:0] ts_q, ts_d;
`endif

    // Exact-match decode: any unaligned or out-of-window address misses all three.
    assign sel_data   = (bus.DataAdr == BASE_ADR);
    assign sel_status = (bus.DataAdr == BASE_ADR + 32'd4);
    assign sel_ctrl   = (bus.DataAdr == BASE_ADR + 32'd8);
    assign bus.Hit    = sel_data | sel_status | sel_ctrl;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = bus.MemWrite & sel_data;
    assign pop      = bus.out_valid & bus.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign ovf_clr  = bus.MemWrite & sel_status & bus.WriteData[2];

    assign bus.out_valid = ~empty & drain_en_q;
    assign bus.out_data  = empty ? 32'h0 : mem[rd_ptr_q];
    assign bus.overflow  = overflow_q;
`ifdef STORE_SINK_TIMESTAMP_EN
    assign bus.out_ts    = empty ? 16'h0 : ts_mem[rd_ptr_q];
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drain_en_d = drain_en_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A new drop outranks a clear arriving in the same cycle.
        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;

        if (bus.MemWrite && sel_ctrl) drain_en_d = bus.WriteData[0];
    end

    always_comb begin
        status             = '0;
        status[0]          = empty;
        status[1]          = full;
        status[2]          = overflow_q;
        status[8 +: CNT_W] = count_q;
`ifdef STORE_SINK_TIMESTAMP_EN
        status[31:16]      = ts_q;
`endif
    end

    always_comb begin
        bus.ReadData = 32'h0;
        if (sel_data)        bus.ReadData = bus.out_data;
        else if (sel_status) bus.ReadData = status;
        else if (sel_ctrl)   bus.ReadData = {31'h0, drain_en_q};
    end

`ifdef STORE_SINK_TIMESTAMP_EN
    assign ts_d = ts_q + 16'd1;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drain_en_q <= 1'b1;
`ifdef STORE_SINK_TIMESTAMP_EN
            ts_q       <= 16'h0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drain_en_q <= drain_en_d;
`ifdef STORE_SINK_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // NOTE: storage has no reset; an empty FIFO never exposes it, so resetting it would only cost area.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q]    <= bus.WriteData;
`ifdef STORE_SINK_TIMESTAMP_EN
            ts_mem[wr_ptr_q] <= ts_q;
`endif
        end
    end
endmodule

// File: tb/tb_mmio_store_sink.sv
// Self-checking bench for mmio_store_sink: directed scenarios plus random traffic against a queue model.
// The monitor compares stream outputs every cycle; the stimulus side checks Hit/ReadData.
module tb_mmio_store_sink;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 8;

    typedef struct {
        logic [31:0] data;
        logic [15:0] ts;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mmio_store_sink_if bus ();

    mmio_store_sink #(.BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: contents in order, sticky flag, drain enable, cycle count.
    entry_t      exp_q[$];
    logic        m_ovf   = 1'b0;
    logic        m_drain = 1'b1;
    logic [15:0] cyc;
    logic [31:0] last_rd;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 16'h0;
        else        cyc <= cyc + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(exp_q.size()) << 8;
        s[2] = m_ovf;
        s[1] = (exp_q.size() == DEPTH);
        s[0] = (exp_q.size() == 0);
`ifdef STORE_SINK_TIMESTAMP_EN
        s[31:16] = cyc;
`endif
        return s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_drain = 1'b1;
    endtask

    // Monitor: at the falling edge, compare stream outputs with the model, then
    // advance the model by what the coming rising edge will do.
    always @(negedge clk) begin
        if (reset) begin
            logic ev;
            ev = (exp_q.size() != 0) && m_drain;
            check("out_valid", 32'(bus.out_valid), 32'(ev));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (ev) begin
                check("out_data", bus.out_data, exp_q[0].data);
`ifdef STORE_SINK_TIMESTAMP_EN
                check("out_ts", 32'(bus.out_ts), 32'(exp_q[0].ts));
`endif
                if (bus.out_ready) void'(exp_q.pop_front());
            end
            if (bus.MemWrite && bus.DataAdr == BASE) begin
                if (exp_q.size() < DEPTH) exp_q.push_back('{data: bus.WriteData, ts: cyc});
                else                      m_ovf = 1'b1;
            end else if (bus.MemWrite && bus.DataAdr == BASE + 32'd4 && bus.WriteData[2]) begin
                m_ovf = 1'b0;
            end
            if (bus.MemWrite && bus.DataAdr == BASE + 32'd8) m_drain = bus.WriteData[0];
        end
    end

    // One bus cycle: drive just after the edge, then check the combinational read path.
    task automatic cyc_drive(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
        logic        hit_e;
        logic [31:0] rd_e;
        logic        care;
        @(posedge clk);
        #1;
        bus.MemWrite  = we;
        bus.DataAdr   = adr;
        bus.WriteData = wd;
        bus.out_ready = rdy;
        #1;
        hit_e = (adr == BASE) || (adr == BASE + 32'd4) || (adr == BASE + 32'd8);
        care  = 1'b1;
        rd_e  = 32'h0;
        if (adr == BASE) begin
            care = (exp_q.size() != 0);
            if (care) rd_e = exp_q[0].data;
        end else if (adr == BASE + 32'd4) begin
            rd_e = model_status();
        end else if (adr == BASE + 32'd8) begin
            rd_e = {31'h0, m_drain};
        end
        last_rd = bus.ReadData;
        check("hit", 32'(bus.Hit), 32'(hit_e));
        if (care) check("read_data", bus.ReadData, rd_e);
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
        cyc_drive(1'b1, adr, wd, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc_drive(1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic status_is(input string name, input logic [15:0] req, input logic rdy);
        cyc_drive(1'b0, BASE + 32'd4, 32'h0, rdy);
        check(name, last_rd & 32'h0000_FFFF, {16'h0, req});
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;
        bus.out_ready = 1'b0;
        #1;
        check("reset_valid", 32'(bus.out_valid), 32'h0);
        check("reset_ovf", 32'(bus.overflow), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Two stores stream out in order with one-cycle latency.
        status_is("status_after_reset", 16'h0001, 1'b1);
        store(BASE, 32'hA5A5_0001, 1'b1);
        store(BASE, 32'hA5A5_0002, 1'b1);
        idle(3, 1'b1);
        status_is("status_drained", 16'h0001, 1'b1);

        // Fill, overflow on the ninth store, drain in order, then clear the flag.
        for (int i = 1; i <= 8; i++) store(BASE, 32'(i), 1'b0);
        status_is("status_full", 16'h0802, 1'b0);
        store(BASE, 32'd9, 1'b0);
        status_is("status_overflow", 16'h0806, 1'b0);
        idle(10, 1'b1);
        store(BASE + 32'd4, 32'h4, 1'b1);
        status_is("status_ovf_cleared", 16'h0001, 1'b1);

        // Full FIFO with a simultaneous push and pop: accepted, no overflow.
        for (int i = 0; i < 8; i++) store(BASE, 32'h100 + 32'(i), 1'b0);
        store(BASE, 32'h0000_DEAD, 1'b1);
        status_is("status_push_pop_full", 16'h0802, 1'b0);
        idle(10, 1'b1);

        // Drain disabled holds words back; re-enable drains them back to back.
        store(BASE + 32'd8, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) store(BASE, 32'h300 + 32'(i), 1'b1);
        status_is("status_drain_off", 16'h0300, 1'b1);
        store(BASE + 32'd8, 32'h1, 1'b1);
        idle(4, 1'b1);
        status_is("status_drain_on", 16'h0001, 1'b1);

        // Asynchronous reset mid-drain with overflow set and five words queued.
        for (int i = 0; i < 9; i++) store(BASE, 32'h500 + 32'(i), 1'b0);
        idle(3, 1'b1);
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_ovf", 32'(bus.overflow), 32'h0);
        #1 reset = 1'b1;
        status_is("status_after_async_rst", 16'h0001, 1'b1);
        cyc_drive(1'b0, BASE + 32'd8, 32'h0, 1'b1);
        check("ctrl_after_async_rst", last_rd, 32'h1);

        // Misses: unaligned, past the window, far away.
        store(BASE + 32'd2, 32'h1111, 1'b0);
        store(BASE + 32'd12, 32'h2222, 1'b0);
        cyc_drive(1'b0, 32'h0000_0200, 32'h0, 1'b0);
        check("miss_readdata", last_rd, 32'h0);
        status_is("status_after_misses", 16'h0001, 1'b0);

        // Pushes three cycles apart; the monitor checks each stamp.
        store(BASE, 32'h7001, 1'b0);
        idle(2, 1'b0);
        store(BASE, 32'h7002, 1'b0);
        idle(4, 1'b1);

        // Random traffic across the window, misses and control writes.
        for (int n = 0; n < 600; n++) begin
            int          sel;
            logic [31:0] adr;
            logic [31:0] wd;
            sel = $urandom_range(0, 9);
            wd  = $urandom;
            case (sel)
                0, 1, 2, 3, 4: adr = BASE;
                5:             adr = BASE + 32'd4;
                6: begin
                    adr   = BASE + 32'd8;
                    wd[0] = ($urandom_range(0, 3) != 0);
                end
                7:             adr = BASE + 32'd2;
                8:             adr = BASE + 32'd12;
                default:       adr = 32'h0000_0200;
            endcase
            cyc_drive(($urandom_range(0, 9) < 7), adr, wd, ($urandom_range(0, 2) == 0));
        end
        store(BASE + 32'd8, 32'h1, 1'b1);
        idle(12, 1'b1);
        status_is("status_final", {13'h0, m_ovf, 2'b01}, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_store_sink.md
Name: mmio_store_sink

Overview:
- Memory-mapped responder on the CPU data-memory write port. It receives the stores the core initiates (MemWrite/DataAdr/WriteData).
- Stores to its data window are pushed into a FIFO, which drains to a downstream consumer over a valid/ready stream.
- CPU reads see a status word, so firmware can poll occupancy and overflow.
- Sits beside data memory under top; address decode is done internally.

Parameters:
- BASE_ADR, 32'h0000_0100, word-aligned base of the 3-word register window.
- DEPTH, 8, FIFO entries; power of 2, 2..64.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- MemWrite  in  1  CPU store strobe, one store per asserted cycle.
- DataAdr  in  32  CPU data address.
- WriteData  in  32  CPU store data.
- ReadData  out  32  combinational read data for the window; 0 outside the window.
- Hit  out  1  combinational; DataAdr within BASE_ADR..BASE_ADR+8, word-aligned.
- out_valid  out  1  stream data valid.
- out_data  out  32  FIFO head word.
- out_ready  in  1  consumer accepts the word this cycle.
- overflow  out  1  sticky drop flag (mirror of STATUS bit 2).

Behaviour:
- Register map, offsets from BASE_ADR:
  - +0 DATA: write pushes WriteData; read returns out_data without popping.
  - +4 STATUS: read returns {zero-pad, count[CNT_W-1:0] at bits 8+, overflow bit2, full bit1, empty bit0}. Write with WriteData[2]=1 clears overflow.
  - +8 CTRL: bit0 drain_en, R/W. Other bits read 0.
- Unaligned addresses (DataAdr[1:0]!=0) and addresses outside the window: no Hit, no side effects, ReadData=0.
- FIFO: circular buffer, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, plus a count register. full = count==DEPTH; empty = count==0.
- push = MemWrite & DATA hit.
- pop = out_valid & out_ready.
- out_valid = !empty & drain_en. out_data = mem[rd_ptr], first-word-fall-through; valid the same cycle count becomes nonzero, i.e. the cycle after the push edge.
- Push accepted when !full, or when full and pop occurs the same cycle. Push+pop: count unchanged, both pointers advance.
- Push rejected (full, no pop): data dropped, overflow set at the next edge. FIFO state unchanged.
- overflow clear and a new drop in the same cycle: set wins.
- out_data must hold stable while out_valid=1 and out_ready=0.
- Clearing drain_en drops out_valid next cycle; FIFO contents retained. A pop in the same cycle as the CTRL write still completes.
- All state updates on the rising clk edge; latency store→out_valid = 1 cycle.
- Reset, asynchronous, any time including mid-drain:
  - count=0, pointers=0, overflow=0, drain_en=1.
  - out_valid=0, overflow output=0.
  - FIFO contents are don't-care and are never exposed while empty.
- Reset deassertion is synchronised externally; the block does not resynchronise it.

Optional Feature:
- Macro STORE_SINK_TIMESTAMP_EN.
- When defined:
  - adds output out_ts[15:0];
  - a 16-bit free-running cycle counter (reset 0, wraps 16'hFFFF→0) is captured alongside each accepted push;
  - out_ts presents the head entry's stamp with the same stability rules as out_data;
  - STATUS bits 31:16 return the live counter value.
- When undefined: no counter, no out_ts port; STATUS bits 31:16 read 0.

Test Plan:
- Reset, then stores 32'hA5A5_0001 and 32'hA5A5_0002 to 0x100 with out_ready=1 → out_valid rises 1 cycle after the first store; words appear in order; STATUS reads 0x0000_0001 afterwards.
- out_ready=0, 8 stores of 1..8 to 0x100 → STATUS = count 8, full=1 (0x0000_0802). 9th store of 9 → overflow=1, FIFO unchanged. Drain → exactly 1..8. Write 0x104 with 0x4 → overflow=0.
- FIFO full, same cycle: store 0xDEAD to 0x100 and out_ready=1 → head pops, 0xDEAD accepted as the 8th entry, overflow stays 0, count stays 8.
- out_ready=1; write CTRL 0x108 = 0; push 3 words → out_valid stays 0, STATUS count=3. Write CTRL=1 → 3 words drain on consecutive cycles.
- Mid-drain, 5 words queued, assert reset=0 for 1 cycle between edges → out_valid=0 and overflow=0 immediately (asynchronously, before the next edge). STATUS reads 0x0000_0001; CTRL reads 1.
- Stores to 0x102 and 0x10C, and a read from 0x200 → Hit=0, no push, ReadData=0. With STORE_SINK_TIMESTAMP_EN, pushes 3 cycles apart → out_ts values differ by 3.
